// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared constants and types for the UART transmitter slice.
//   DEFAULT_CLKS_PER_BIT : baud divisor used when the parent does not override it
//   WORD_LEN             : data bits per frame
//   BAUD_CNT_W           : width of the baud counter (covers divisors up to 65535)
//   tx_state_t           : transmitter frame states
package uart_tx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 234;
    localparam int WORD_LEN             = 8;
    localparam int BAUD_CNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO sitting in front of the transmitter.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   wr_en       : push request (ignored while full, even if a pop happens on the same edge)
//   wr_data     : byte pushed when wr_en is accepted
//   rd_en       : pop request from the transmitter (ignored while empty)
//   rd_data     : current head byte, valid whenever empty=0
//   full, empty : registered occupancy flags, updated on the same edge as the occupancy
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  do_write;
    logic                  do_read;

    // Acceptance is judged on the flags as they stood before the edge, so a
    // write into a full FIFO is lost even when a byte leaves on that edge.
    assign do_write = wr_en && !full;
    assign do_read  = rd_en && !empty;
    assign rd_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_write, do_read})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Flags are computed from the next occupancy so they are flop outputs
    // that always agree with the count after every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 UART transmitter with a transmit FIFO.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   wr_en      : push one byte per asserted cycle
//   wr_data    : byte to push
//   full       : FIFO holds FIFO_DEPTH bytes
//   empty      : FIFO holds no bytes
//   busy       : a frame is on the line or bytes are waiting
//   uart_out   : serial line, idle high, driven from a flop
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       uart_out
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]            LAST_BIT  = 3'(WORD_LEN - 1);

    tx_state_t               state, state_next;
    logic [BAUD_CNT_W-1:0]   baud_cnt, baud_cnt_next;
    logic [2:0]              bit_idx, bit_idx_next;
    logic [WORD_LEN-1:0]     shift_reg, shift_next;
    logic                    line_next;
    logic                    pop;
    logic                    bit_done;
    logic [WORD_LEN-1:0]     fifo_head;

    uart_tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (WORD_LEN)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (empty)
    );

    assign bit_done = (baud_cnt == BAUD_LAST);

    // Both inputs are flops, so busy never depends combinationally on wr_en.
    assign busy = (state != IDLE) || !empty;

    // Next-state and datapath: a pop (from IDLE, or at the very end of a stop
    // bit) loads the head byte and restarts the bit timing; the stop-bit pop
    // chains frames with no idle gap. The line value is derived from the next
    // state so uart_out can be a plain register.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift_reg;
        line_next     = 1'b1;

        if (state != IDLE) begin
            baud_cnt_next = bit_done ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop) begin
            shift_next    = fifo_head;
            baud_cnt_next = '0;
            bit_idx_next  = '0;
        end

        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_next[0];
            default: line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_out  <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            uart_out  <= line_next;
        end
    end

endmodule
